// File: rtl/mem_arbiter.sv
// Three-requester arbiter in front of the single-outstanding slowmem port (strobe/mfc handshake).
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-state abort that returns 16'hffff with err.
module mem_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      req_rnotw_i,
    input  logic [16*NREQ-1:0]   req_addr_i,
    input  logic [16*NREQ-1:0]   req_wdata_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [15:0]          rdata_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic                 mem_strobe_o,
    output logic                 mem_rnotw_o,
    output logic [15:0]          mem_addr_o,
    output logic [15:0]          mem_wdata_o,
    input  logic                 mem_mfc_i,
    input  logic [15:0]          mem_rdata_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [1:0]      winner_q, winner_d;
    logic            rnotw_q, rnotw_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [15:0]     rdata_q, rdata_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            mem_strobe_q, mem_strobe_d;
    logic            mem_rnotw_q, mem_rnotw_d;
    logic [15:0]     mem_addr_q, mem_addr_d;
    logic [15:0]     mem_wdata_q, mem_wdata_d;
    logic [1:0]      pick;

    logic [15:0] addr_arr  [NREQ];
    logic [15:0] wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            localparam logic [1:0] IDX = 2'(gi);
            assign addr_arr[gi]  = req_addr_i[16*gi +: 16];
            assign wdata_arr[gi] = req_wdata_i[16*gi +: 16];
            assign ack_d[gi]     = (state_q == S_ACK) && (winner_q == IDX);
        end
    endgenerate

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          timed_out_q, timed_out_d;
    logic          err_q, err_d;
`endif

    // Data cache has absolute priority; the two instruction caches alternate on contention.
    always_comb begin
        pick = 2'd0;
        if (req_i[2])
            pick = 2'd2;
        else if (req_i[0] && req_i[1])
            pick = rr_ptr_q ? 2'd0 : 2'd1;
        else if (req_i[1])
            pick = 2'd1;
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        rnotw_d  = rnotw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rr_ptr_d = rr_ptr_q;
        rdata_d  = rdata_q;
`ifdef MEM_TIMEOUT_EN
        timed_out_d = timed_out_q;
        tcnt_d      = (state_q == S_WAIT) ? tcnt_q + 1'b1 : '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    winner_d = pick;
                    rnotw_d  = req_rnotw_i[pick];
                    addr_d   = addr_arr[pick];
                    wdata_d  = wdata_arr[pick];
                    if (pick != 2'd2)
                        rr_ptr_d = pick[0];
`ifdef MEM_TIMEOUT_EN
                    timed_out_d = 1'b0;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = rnotw_q ? S_WAIT : S_ACK;
            S_WAIT: begin
                if (mem_mfc_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = S_ACK;
                end
`ifdef MEM_TIMEOUT_EN
                // Leaving at count TIMEOUT-2 puts the ack exactly TIMEOUT cycles after WAIT entry.
                else if (tcnt_q == CW'(TIMEOUT - 2)) begin
                    rdata_d     = 16'hffff;
                    timed_out_d = 1'b1;
                    state_d     = S_ACK;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d       = (state_d != S_IDLE);
        mem_strobe_d = (state_q == S_ISSUE);
        mem_rnotw_d  = mem_rnotw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if (state_q == S_ISSUE) begin
            mem_rnotw_d = rnotw_q;
            mem_addr_d  = addr_q;
            mem_wdata_d = wdata_q;
        end
`ifdef MEM_TIMEOUT_EN
        err_d = (state_q == S_ACK) && timed_out_q;
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            winner_q     <= 2'd0;
            rnotw_q      <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            rr_ptr_q     <= 1'b0;
            rdata_q      <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            mem_strobe_q <= 1'b0;
            mem_rnotw_q  <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            tcnt_q       <= '0;
            timed_out_q  <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            rnotw_q      <= rnotw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rr_ptr_q     <= rr_ptr_d;
            rdata_q      <= rdata_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            mem_strobe_q <= mem_strobe_d;
            mem_rnotw_q  <= mem_rnotw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
`ifdef MEM_TIMEOUT_EN
            tcnt_q       <= tcnt_d;
            timed_out_q  <= timed_out_d;
            err_q        <= err_d;
`endif
        end
    end

    assign ack_o        = ack_q;
    assign rdata_o      = rdata_q;
    assign busy_o       = busy_q;
    assign mem_strobe_o = mem_strobe_q;
    assign mem_rnotw_o  = mem_rnotw_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
`ifdef MEM_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
